// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one physical memory port among NUM_REQ requesters.
// Requests are arbitrated round-robin into a single registered issue slot.
// Read IDs are queued in order so each physical read response is routed back
// to the requester that issued it. Writes produce no response.
module mem_port_arbiter #(
    parameter int NUM_REQ         = 2,
    parameter int ADDR_W          = 32,
    parameter int DATA_W          = 512,
    parameter int MAX_OUTSTANDING = 8
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NUM_REQ-1:0]                vir_req_valid,
    input  logic [NUM_REQ-1:0]                vir_req_is_write,
    input  logic [NUM_REQ*ADDR_W-1:0]         vir_req_addr,
    input  logic [NUM_REQ*DATA_W-1:0]         vir_req_data,
    output logic [NUM_REQ-1:0]                vir_req_grant,
    output logic [NUM_REQ-1:0]                vir_resp_valid,
    output logic [DATA_W-1:0]                 vir_resp_data,
    input  logic [NUM_REQ-1:0]                vir_resp_grant,
    output logic                              phy_req_valid,
    output logic                              phy_req_is_write,
    output logic [ADDR_W-1:0]                 phy_req_addr,
    output logic [DATA_W-1:0]                 phy_req_data,
    input  logic                              phy_req_grant,
    input  logic                              phy_resp_valid,
    input  logic [DATA_W-1:0]                 phy_resp_data,
    output logic                              phy_resp_grant,
    output logic [$clog2(MAX_OUTSTANDING):0]  outstanding,
    output logic                              resp_err
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int PTR_W = $clog2(MAX_OUTSTANDING);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic {REQ_IDLE, REQ_ISSUE} req_state_t;
    typedef enum logic {RSP_IDLE, RSP_HOLD}  rsp_state_t;

    req_state_t          req_state, req_next;
    rsp_state_t          rsp_state, rsp_next;

    // Arbitration
    logic [IDX_W-1:0]    rr_ptr;
    logic [NUM_REQ-1:0]  eligible;
    logic [NUM_REQ-1:0]  blocked;
    logic                found;
    logic [IDX_W-1:0]    win_idx;
    logic [IDX_W-1:0]    blk_idx;
    logic [IDX_W-1:0]    next_ptr;
    logic                win_write;
    logic [ADDR_W-1:0]   win_addr;
    logic [DATA_W-1:0]   win_data;
    int                  arb_dist;
    int                  win_dist;
    int                  blk_dist;
    logic                req_take;

    // Read ID FIFO
    logic [IDX_W-1:0]    fifo_mem [MAX_OUTSTANDING];
    logic [PTR_W-1:0]    wr_ptr;
    logic [PTR_W-1:0]    rd_ptr;
    logic [CNT_W-1:0]    count;
    logic                push;
    logic                pop;

    // Response path
    logic                rsp_accept;
    logic                rsp_drop;
    logic                resp_ack;
    logic [IDX_W-1:0]    resp_id;

    assign outstanding = count;

    // Round-robin search: nearest eligible index at or after rr_ptr; a blocked
    // reader that sits ahead of the winner keeps the pointer so it is not skipped.
    always_comb begin
        eligible  = '0;
        blocked   = '0;
        arb_dist  = 0;
        win_dist  = NUM_REQ;
        blk_dist  = NUM_REQ;
        win_idx   = '0;
        blk_idx   = '0;
        win_write = 1'b0;
        win_addr  = '0;
        win_data  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            eligible[i] = vir_req_valid[i] &&
                          (vir_req_is_write[i] || (count < CNT_W'(MAX_OUTSTANDING)));
            blocked[i]  = vir_req_valid[i] && !eligible[i];
            arb_dist    = (i - int'(rr_ptr) + NUM_REQ) % NUM_REQ;
            if (eligible[i] && (arb_dist < win_dist)) begin
                win_dist  = arb_dist;
                win_idx   = IDX_W'(i);
                win_write = vir_req_is_write[i];
                win_addr  = vir_req_addr[i*ADDR_W +: ADDR_W];
                win_data  = vir_req_data[i*DATA_W +: DATA_W];
            end
            if (blocked[i] && (arb_dist < blk_dist)) begin
                blk_dist = arb_dist;
                blk_idx  = IDX_W'(i);
            end
        end
        found = (win_dist < NUM_REQ);
        if (blk_dist < win_dist) begin
            next_ptr = blk_idx;
        end else if (int'(win_idx) == NUM_REQ - 1) begin
            next_ptr = '0;
        end else begin
            next_ptr = win_idx + 1'b1;
        end
    end

    // Request FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            req_state <= REQ_IDLE;
        end else begin
            req_state <= req_next;
        end
    end

    // Request FSM next state: select in idle, hold the slot until memory accepts
    always_comb begin
        req_next = req_state;
        case (req_state)
            REQ_IDLE:  if (found)         req_next = REQ_ISSUE;
            REQ_ISSUE: if (phy_req_grant) req_next = REQ_IDLE;
            default:                      req_next = REQ_IDLE;
        endcase
    end

    // Request FSM outputs: slot valid while issuing, reads push their ID on selection
    always_comb begin
        phy_req_valid = (req_state == REQ_ISSUE);
        req_take      = (req_state == REQ_IDLE) && found;
        push          = req_take && !win_write;
    end

    // Issue slot, requester grant pulse and round-robin pointer
    always_ff @(posedge clk) begin
        if (rst) begin
            phy_req_is_write <= 1'b0;
            phy_req_addr     <= '0;
            phy_req_data     <= '0;
            vir_req_grant    <= '0;
            rr_ptr           <= '0;
        end else begin
            vir_req_grant <= '0;
            if (req_take) begin
                phy_req_is_write <= win_write;
                phy_req_addr     <= win_addr;
                phy_req_data     <= win_data;
                rr_ptr           <= next_ptr;
                for (int i = 0; i < NUM_REQ; i++) begin
                    vir_req_grant[i] <= (win_idx == IDX_W'(i));
                end
            end
        end
    end

    // Read ID FIFO pointers and occupancy; push and pop may coincide
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Read ID FIFO storage
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= win_idx;
    end

    // Response FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_state <= RSP_IDLE;
        end else begin
            rsp_state <= rsp_next;
        end
    end

    // Response FSM next state: hold a routed response until its owner takes it
    always_comb begin
        rsp_next = rsp_state;
        case (rsp_state)
            RSP_IDLE: if (pop)      rsp_next = RSP_HOLD;
            RSP_HOLD: if (resp_ack) rsp_next = RSP_IDLE;
            default:                rsp_next = RSP_IDLE;
        endcase
    end

    // Response FSM outputs; the accept is masked while our grant pulse is out,
    // because memory only drops its valid after seeing that pulse
    always_comb begin
        rsp_accept     = (rsp_state == RSP_IDLE) && phy_resp_valid && !phy_resp_grant;
        pop            = rsp_accept && (count != '0);
        rsp_drop       = rsp_accept && (count == '0);
        resp_ack       = 1'b0;
        vir_resp_valid = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (resp_id == IDX_W'(i)) begin
                vir_resp_valid[i] = (rsp_state == RSP_HOLD);
                resp_ack          = (rsp_state == RSP_HOLD) && vir_resp_grant[i];
            end
        end
    end

    // Response capture, memory accept pulse and sticky orphan-response flag
    always_ff @(posedge clk) begin
        if (rst) begin
            phy_resp_grant <= 1'b0;
            resp_err       <= 1'b0;
            vir_resp_data  <= '0;
            resp_id        <= '0;
        end else begin
            phy_resp_grant <= rsp_accept;
            if (rsp_drop) resp_err <= 1'b1;
            if (pop) begin
                vir_resp_data <= phy_resp_data;
                resp_id       <= fifo_mem[rd_ptr];
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed testbench for mem_port_arbiter (NUM_REQ=2, MAX_OUTSTANDING=8).
module tb_mem_port_arbiter;

    localparam int NUM_REQ = 2;
    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 512;
    localparam int MAX_OUT = 8;

    logic                        clk;
    logic                        rst;
    logic [NUM_REQ-1:0]          vir_req_valid;
    logic [NUM_REQ-1:0]          vir_req_is_write;
    logic [NUM_REQ*ADDR_W-1:0]   vir_req_addr;
    logic [NUM_REQ*DATA_W-1:0]   vir_req_data;
    logic [NUM_REQ-1:0]          vir_req_grant;
    logic [NUM_REQ-1:0]          vir_resp_valid;
    logic [DATA_W-1:0]           vir_resp_data;
    logic [NUM_REQ-1:0]          vir_resp_grant;
    logic                        phy_req_valid;
    logic                        phy_req_is_write;
    logic [ADDR_W-1:0]           phy_req_addr;
    logic [DATA_W-1:0]           phy_req_data;
    logic                        phy_req_grant;
    logic                        phy_resp_valid;
    logic [DATA_W-1:0]           phy_resp_data;
    logic                        phy_resp_grant;
    logic [3:0]                  outstanding;
    logic                        resp_err;

    int n_err = 0;
    int n_chk = 0;

    logic [1:0]  order [8];
    logic [31:0] rr_data [8];
    logic [1:0]  exp_v;
    int          n_g, g0, g1, cnt, bad;
    bit          seen;

    mem_port_arbiter #(
        .NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_OUTSTANDING(MAX_OUT)
    ) dut (
        .clk(clk), .rst(rst),
        .vir_req_valid(vir_req_valid), .vir_req_is_write(vir_req_is_write),
        .vir_req_addr(vir_req_addr), .vir_req_data(vir_req_data),
        .vir_req_grant(vir_req_grant), .vir_resp_valid(vir_resp_valid),
        .vir_resp_data(vir_resp_data), .vir_resp_grant(vir_resp_grant),
        .phy_req_valid(phy_req_valid), .phy_req_is_write(phy_req_is_write),
        .phy_req_addr(phy_req_addr), .phy_req_data(phy_req_data),
        .phy_req_grant(phy_req_grant), .phy_resp_valid(phy_resp_valid),
        .phy_resp_data(phy_resp_data), .phy_resp_grant(phy_resp_grant),
        .outstanding(outstanding), .resp_err(resp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [DATA_W-1:0] got,
                         input logic [DATA_W-1:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        vir_req_valid    = '0;
        vir_req_is_write = '0;
        vir_req_addr     = '0;
        vir_req_data     = '0;
        vir_resp_grant   = '0;
        phy_req_grant    = 1'b0;
        phy_resp_valid   = 1'b0;
        phy_resp_data    = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_inputs();
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Present one request and wait (bounded) for its grant pulse.
    task automatic issue(input int idx, input logic wr, input logic [ADDR_W-1:0] a,
                         input logic [DATA_W-1:0] d);
        bit got_it;
        got_it = 1'b0;
        vir_req_valid[idx]                 = 1'b1;
        vir_req_is_write[idx]              = wr;
        vir_req_addr[idx*ADDR_W +: ADDR_W] = a;
        vir_req_data[idx*DATA_W +: DATA_W] = d;
        for (int k = 0; k < 10 && !got_it; k++) begin
            tick();
            if (vir_req_grant[idx]) got_it = 1'b1;
        end
        check("issue_grant", got_it, 1);
        vir_req_valid[idx] = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        clear_inputs();
        rr_data = '{32'h98, 32'h1234, 32'h5555, 32'h7777, 32'hA1, 32'hB2, 32'hC3, 32'hD4};
        for (int k = 0; k < 8; k++) order[k] = '0;

        // ---------------- reset state ----------------
        tick();
        tick();
        check("rst_req_grant", vir_req_grant, 0);
        check("rst_resp_valid", vir_resp_valid, 0);
        check("rst_resp_data", vir_resp_data, 0);
        check("rst_phy_valid", phy_req_valid, 0);
        check("rst_phy_wr", phy_req_is_write, 0);
        check("rst_phy_addr", phy_req_addr, 0);
        check("rst_phy_data", phy_req_data, 0);
        check("rst_phy_rgnt", phy_resp_grant, 0);
        check("rst_outst", outstanding, 0);
        check("rst_err", resp_err, 0);
        rst = 1'b0;

        // ---------------- single read ----------------
        vir_req_valid = 2'b01;
        vir_req_addr[0 +: ADDR_W] = 32'h0003_0003;
        tick();
        check("rd_grant", vir_req_grant, 2'b01);
        check("rd_phy_valid", phy_req_valid, 1);
        check("rd_phy_addr", phy_req_addr, 32'h0003_0003);
        check("rd_phy_wr", phy_req_is_write, 0);
        check("rd_outst1", outstanding, 1);
        vir_req_valid = 2'b00;
        phy_req_grant = 1'b1;
        tick();
        check("rd_grant_pulse", vir_req_grant, 0);
        check("rd_phy_drop", phy_req_valid, 0);
        phy_req_grant  = 1'b0;
        phy_resp_valid = 1'b1;
        phy_resp_data  = 512'h42;
        tick();
        check("rd_phy_rgnt", phy_resp_grant, 1);
        check("rd_resp_valid", vir_resp_valid, 2'b01);
        check("rd_resp_data", vir_resp_data, 512'h42);
        check("rd_outst0", outstanding, 0);
        phy_resp_valid = 1'b0;
        vir_resp_grant = 2'b01;
        tick();
        check("rd_resp_drop", vir_resp_valid, 0);
        check("rd_rgnt_pulse", phy_resp_grant, 0);
        vir_resp_grant = 2'b00;

        // ---------------- round-robin contention ----------------
        do_reset();
        phy_req_grant = 1'b1;
        vir_req_addr  = {32'h20, 32'h10};
        vir_req_valid = 2'b11;
        n_g = 0; g0 = 0; g1 = 0;
        for (int k = 0; k < 40 && n_g < 8; k++) begin
            tick();
            if (vir_req_grant != 2'b00) begin
                order[n_g] = vir_req_grant;
                n_g++;
                if (vir_req_grant[0]) begin
                    g0++;
                    if (g0 == 4) vir_req_valid[0] = 1'b0;
                end
                if (vir_req_grant[1]) begin
                    g1++;
                    if (g1 == 4) vir_req_valid[1] = 1'b0;
                end
            end
        end
        check("rr_count", n_g, 8);
        for (int k = 0; k < 8; k++) begin
            check($sformatf("rr_order%0d", k), order[k], (k % 2 == 0) ? 2'b01 : 2'b10);
        end
        check("rr_outst8", outstanding, 8);
        for (int k = 0; k < 8; k++) begin
            exp_v          = (k % 2 == 0) ? 2'b01 : 2'b10;
            phy_resp_valid = 1'b1;
            phy_resp_data  = DATA_W'(rr_data[k]);
            tick();
            check($sformatf("rr_rgnt%0d", k), phy_resp_grant, 1);
            check($sformatf("rr_rvld%0d", k), vir_resp_valid, exp_v);
            check($sformatf("rr_rdata%0d", k), vir_resp_data, DATA_W'(rr_data[k]));
            phy_resp_valid = 1'b0;
            vir_resp_grant = exp_v;
            tick();
            vir_resp_grant = 2'b00;
        end
        check("rr_resp_idle", vir_resp_valid, 0);
        check("rr_outst0", outstanding, 0);

        // ---------------- mixed write then read ----------------
        do_reset();
        vir_req_valid    = 2'b10;
        vir_req_is_write = 2'b10;
        vir_req_addr[ADDR_W +: ADDR_W] = 32'h100;
        vir_req_data[DATA_W +: DATA_W] = 512'hABCD;
        tick();
        check("mx_wr_grant", vir_req_grant, 2'b10);
        check("mx_wr_is_wr", phy_req_is_write, 1);
        check("mx_wr_addr", phy_req_addr, 32'h100);
        check("mx_wr_data", phy_req_data, 512'hABCD);
        check("mx_wr_outst", outstanding, 0);
        vir_req_valid = 2'b00;
        phy_req_grant = 1'b1;
        tick();
        check("mx_wr_drop", phy_req_valid, 0);
        phy_req_grant    = 1'b0;
        vir_req_is_write = 2'b00;
        vir_req_addr[0 +: ADDR_W] = 32'h200;
        vir_req_valid    = 2'b01;
        tick();
        check("mx_rd_grant", vir_req_grant, 2'b01);
        check("mx_rd_is_wr", phy_req_is_write, 0);
        check("mx_rd_addr", phy_req_addr, 32'h200);
        check("mx_rd_outst", outstanding, 1);
        vir_req_valid = 2'b00;
        phy_req_grant = 1'b1;
        tick();
        phy_req_grant  = 1'b0;
        phy_resp_valid = 1'b1;
        phy_resp_data  = 512'h77;
        tick();
        check("mx_resp_vld", vir_resp_valid, 2'b01);
        check("mx_resp_data", vir_resp_data, 512'h77);
        phy_resp_valid = 1'b0;
        vir_resp_grant = 2'b01;
        tick();
        vir_resp_grant = 2'b00;
        check("mx_resp_idle", vir_resp_valid, 0);
        check("mx_outst0", outstanding, 0);

        // ---------------- FIFO full ----------------
        do_reset();
        phy_req_grant = 1'b1;
        vir_req_addr[0 +: ADDR_W] = 32'h40;
        vir_req_valid = 2'b01;
        n_g = 0;
        for (int k = 0; k < 40 && n_g < 8; k++) begin
            tick();
            if (vir_req_grant[0]) n_g++;
        end
        check("full_fill", n_g, 8);
        check("full_outst8", outstanding, 8);
        cnt = 0;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (vir_req_grant[0]) cnt++;
        end
        check("full_rd_blocked", cnt, 0);
        vir_req_is_write = 2'b10;
        vir_req_addr[ADDR_W +: ADDR_W] = 32'h300;
        vir_req_valid = 2'b11;
        tick();
        check("full_wr_grant", vir_req_grant, 2'b10);
        check("full_wr_addr", phy_req_addr, 32'h300);
        vir_req_valid  = 2'b01;
        phy_resp_valid = 1'b1;
        phy_resp_data  = 512'h9;
        tick();
        check("full_rgnt", phy_resp_grant, 1);
        check("full_outst7", outstanding, 7);
        phy_resp_valid = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 2 && !seen; k++) begin
            tick();
            if (vir_req_grant[0]) seen = 1'b1;
        end
        check("full_9th_grant", seen, 1);
        vir_req_valid = 2'b00;
        check("full_outst_refill", outstanding, 8);

        // ---------------- response back-pressure ----------------
        do_reset();
        phy_req_grant = 1'b1;
        issue(0, 1'b0, 32'h500, '0);
        issue(0, 1'b0, 32'h540, '0);
        check("bp_outst2", outstanding, 2);
        phy_resp_valid = 1'b1;
        phy_resp_data  = 512'hAAAA;
        tick();
        check("bp_rgnt_first", phy_resp_grant, 1);
        phy_resp_data = 512'hBBBB;
        bad = 0;
        cnt = 0;
        for (int k = 0; k < 22; k++) begin
            vir_resp_grant = (k < 20) ? 2'b00 : 2'b10;
            tick();
            if (vir_resp_valid !== 2'b01 || vir_resp_data !== 512'hAAAA) bad++;
            if (phy_resp_grant) cnt++;
        end
        check("bp_stable", bad, 0);
        check("bp_rgnt_once", cnt, 0);
        vir_resp_grant = 2'b01;
        tick();
        check("bp_first_done", vir_resp_valid, 0);
        vir_resp_grant = 2'b00;
        tick();
        check("bp_rgnt_second", phy_resp_grant, 1);
        check("bp_second_vld", vir_resp_valid, 2'b01);
        check("bp_second_data", vir_resp_data, 512'hBBBB);
        phy_resp_valid = 1'b0;
        vir_resp_grant = 2'b01;
        tick();
        vir_resp_grant = 2'b00;
        check("bp_outst0", outstanding, 0);

        // ---------------- orphan response and reset mid-issue ----------------
        do_reset();
        phy_resp_valid = 1'b1;
        phy_resp_data  = 512'h5;
        tick();
        check("err_rgnt", phy_resp_grant, 1);
        check("err_flag", resp_err, 1);
        check("err_no_route", vir_resp_valid, 0);
        phy_resp_valid = 1'b0;
        tick();
        check("err_rgnt_once", phy_resp_grant, 0);
        check("err_sticky", resp_err, 1);
        vir_req_valid = 2'b01;
        tick();
        check("ri_issue", phy_req_valid, 1);
        check("ri_outst1", outstanding, 1);
        vir_req_valid = 2'b00;
        rst = 1'b1;
        tick();
        check("ri_phy_valid", phy_req_valid, 0);
        check("ri_outst0", outstanding, 0);
        check("ri_err_clr", resp_err, 0);
        check("ri_no_grant", vir_req_grant, 0);
        rst = 1'b0;
        tick();
        check("ri_stay_idle", phy_req_valid, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
